cmp_share_arb: RTL and testbench

//  Round-robin arbiter/scheduler that shares one branch comparator between two

---
 rtl/cmp_share_if.sv | 38 +++
 rtl/cmp_share_arb.sv | 133 +++++++++++++
 tb/tb_cmp_share_arb.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/cmp_share_if.sv
// Request/compare/response bundle between two requesters, the shared
// branch comparator and the arbiter that owns it.
interface cmp_share_if #(
    parameter int W = 32
);
    // requester side
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic [2:0]   req0_op;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic [2:0]   req1_op;
    // shared comparator
    logic [W-1:0] cmp_a;
    logic [W-1:0] cmp_b;
    logic [2:0]   cmp_op;
    logic         cmp_out;
    // response
    logic [1:0]   rsp_valid;
    logic [1:0]   rsp_ready;
    logic         rsp_out;

    // arbiter side
    modport slave (
        input  req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op,
        input  cmp_out, rsp_ready,
        output req_ready, cmp_a, cmp_b, cmp_op, rsp_valid, rsp_out
    );

    // requesters plus comparator (environment side)
    modport master (
        output req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op,
        output cmp_out, rsp_ready,
        input  req_ready, cmp_a, cmp_b, cmp_op, rsp_valid, rsp_out
    );
endinterface

// File: rtl/cmp_share_arb.sv
// Round-robin sharing of one branch comparator between the branch unit
// (requester 0) and the set-less-than path (requester 1). The granted
// operands go straight to the comparator; its result is captured into a
// single-entry response register with per-requester valid/ready.

// Saturating grant counter for one requester; clear wins over increment.
module cmp_share_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    // count grants, stick at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && (cnt != {CNT_W{1'b1}}))
            cnt <= cnt + 1'b1;
    end
endmodule

module cmp_share_arb #(
    parameter int W     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    cmp_share_if.slave       bus,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
);
    localparam int NUM_REQ = 2;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
    } cmp_req_t;

    cmp_req_t [NUM_REQ-1:0]            reqs;
    logic     [NUM_REQ-1:0][CNT_W-1:0] cnt;

    logic               gnt_vld;
    logic               gnt_id;
    logic [NUM_REQ-1:0] gnt_oh;
    logic               can_acc;
    logic               out_valid;

    logic [NUM_REQ-1:0] rsp_valid_q;
    logic               rsp_out_q;
    logic               out_id_q;
    logic               last_grant_q;

    assign reqs[0] = '{a: bus.req0_a, b: bus.req0_b, op: bus.req0_op};
    assign reqs[1] = '{a: bus.req1_a, b: bus.req1_b, op: bus.req1_op};

    // The slot frees up either when empty or when its owner is draining it
    // this very cycle, so back-to-back responses need no bubble.
    assign out_valid = |rsp_valid_q;
    assign can_acc   = !out_valid || bus.rsp_ready[out_id_q];

    // Grant selection: sole requester wins, a tie goes to whoever did not
    // win last time. Depends only on req_valid, rsp_ready and state, never
    // on cmp_out, so requesters see no loop through the comparator.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = 1'b0;
        if (can_acc) begin
            case (bus.req_valid)
                2'b01: begin gnt_vld = 1'b1; gnt_id = 1'b0;          end
                2'b10: begin gnt_vld = 1'b1; gnt_id = 1'b1;          end
                2'b11: begin gnt_vld = 1'b1; gnt_id = ~last_grant_q; end
                default: ;
            endcase
        end
    end

    assign gnt_oh        = gnt_vld ? (2'b01 << gnt_id) : 2'b00;
    assign bus.req_ready = gnt_oh;

    // Comparator inputs are zeroed when idle so they do not toggle with
    // whatever an unserved requester happens to present.
    always_comb begin
        bus.cmp_a  = '0;
        bus.cmp_b  = '0;
        bus.cmp_op = '0;
        if (gnt_vld) begin
            bus.cmp_a  = reqs[gnt_id].a;
            bus.cmp_b  = reqs[gnt_id].b;
            bus.cmp_op = reqs[gnt_id].op;
        end
    end

    // Response register: load on accept, clear when drained, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q  <= '0;
            rsp_out_q    <= 1'b0;
            out_id_q     <= 1'b0;
            last_grant_q <= 1'b1;
        end else if (gnt_vld) begin
            rsp_valid_q  <= gnt_oh;
            rsp_out_q    <= bus.cmp_out;
            out_id_q     <= gnt_id;
            last_grant_q <= gnt_id;
        end else if (out_valid && bus.rsp_ready[out_id_q]) begin
            rsp_valid_q  <= '0;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_out   = rsp_out_q;

    // One saturating counter per requester.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
        cmp_share_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr_cnt),
            .inc   (gnt_oh[i]),
            .cnt   (cnt[i])
        );
    end

    assign grant_cnt0 = cnt[0];
    assign grant_cnt1 = cnt[1];
endmodule

// File: tb/tb_cmp_share_arb.sv
// Directed bench for cmp_share_arb with a behavioural branch comparator.
module tb_cmp_share_arb;
    localparam int W     = 32;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             clr_cnt;
    logic [CNT_W-1:0] grant_cnt0;
    logic [CNT_W-1:0] grant_cnt1;

    int total = 0;
    int bad   = 0;

    cmp_share_if #(.W(W)) ifc ();

    cmp_share_arb #(.W(W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (ifc),
        .clr_cnt    (clr_cnt),
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RISC-V branch comparator; reserved funct3 returns 0
    always_comb begin
        ifc.cmp_out = 1'b0;
        case (ifc.cmp_op)
            3'b000: ifc.cmp_out = (ifc.cmp_a == ifc.cmp_b);
            3'b001: ifc.cmp_out = (ifc.cmp_a != ifc.cmp_b);
            3'b100: ifc.cmp_out = ($signed(ifc.cmp_a) <  $signed(ifc.cmp_b));
            3'b101: ifc.cmp_out = ($signed(ifc.cmp_a) >= $signed(ifc.cmp_b));
            3'b110: ifc.cmp_out = (ifc.cmp_a <  ifc.cmp_b);
            3'b111: ifc.cmp_out = (ifc.cmp_a >= ifc.cmp_b);
            default: ifc.cmp_out = 1'b0;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        clr_cnt       = 1'b0;
        ifc.req_valid = 2'b00;
        ifc.rsp_ready = 2'b00;
        ifc.req0_a    = '0;
        ifc.req0_b    = '0;
        ifc.req0_op   = '0;
        ifc.req1_a    = '0;
        ifc.req1_b    = '0;
        ifc.req1_op   = '0;

        // reset state
        #3;
        chk("rst_rsp_valid", ifc.rsp_valid, 2'b00);
        chk("rst_rsp_out",   ifc.rsp_out,   1'b0);
        chk("rst_cnt0",      grant_cnt0,    4'd0);
        chk("rst_cnt1",      grant_cnt1,    4'd0);
        chk("rst_req_ready", ifc.req_ready, 2'b00);
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();

        // 1: single request from port 0, BEQ 5==5
        ifc.req0_a = 32'd5; ifc.req0_b = 32'd5; ifc.req0_op = 3'b000;
        ifc.req_valid = 2'b01;
        #1;
        chk("t1_req_ready", ifc.req_ready, 2'b01);
        chk("t1_cmp_a",     ifc.cmp_a,     32'd5);
        chk("t1_cmp_b",     ifc.cmp_b,     32'd5);
        chk("t1_cmp_op",    ifc.cmp_op,    3'b000);
        tick();
        ifc.req_valid = 2'b00;
        chk("t1_rsp_valid", ifc.rsp_valid, 2'b01);
        chk("t1_rsp_out",   ifc.rsp_out,   1'b1);
        chk("t1_cnt0",      grant_cnt0,    4'd1);
        ifc.rsp_ready = 2'b11;
        #1;
        chk("t1_idle_cmp_a", ifc.cmp_a, 32'd0);
        tick();
        chk("t1_drained", ifc.rsp_valid, 2'b00);
        ifc.rsp_ready = 2'b00;

        // 6: port 1 BLT -1 < 1, then BLTU under backpressure
        ifc.req1_a = 32'hFFFF_FFFF; ifc.req1_b = 32'd1; ifc.req1_op = 3'b100;
        ifc.req_valid = 2'b10;
        #1;
        chk("t6_req_ready", ifc.req_ready, 2'b10);
        chk("t6_cmp_op",    ifc.cmp_op,    3'b100);
        chk("t6_cmp_a",     ifc.cmp_a,     32'hFFFF_FFFF);
        chk("t6_cmp_b",     ifc.cmp_b,     32'd1);
        tick();
        chk("t6_rsp_valid", ifc.rsp_valid, 2'b10);
        chk("t6_rsp_out",   ifc.rsp_out,   1'b1);
        ifc.req1_op = 3'b110;
        #1;
        chk("t6_bp_ready", ifc.req_ready, 2'b00);
        tick();
        chk("t6_bp_hold_valid", ifc.rsp_valid, 2'b10);
        chk("t6_bp_hold_out",   ifc.rsp_out,   1'b1);
        ifc.rsp_ready = 2'b10;
        #1;
        chk("t6_swap_ready", ifc.req_ready, 2'b10);
        chk("t6_swap_op",    ifc.cmp_op,    3'b110);
        tick();
        chk("t6_bltu_valid", ifc.rsp_valid, 2'b10);
        chk("t6_bltu_out",   ifc.rsp_out,   1'b0);
        chk("t6_cnt1",       grant_cnt1,    4'd2);
        ifc.req_valid = 2'b00;
        ifc.rsp_ready = 2'b11;
        tick();
        chk("t6_drained", ifc.rsp_valid, 2'b00);

        // counter clear
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        chk("clr_cnt0", grant_cnt0, 4'd0);
        chk("clr_cnt1", grant_cnt1, 4'd0);

        // 2: tie held for 4 cycles, last grant was port 1
        ifc.req0_a = 32'd1; ifc.req0_b = 32'd2; ifc.req0_op = 3'b000;
        ifc.req_valid = 2'b11;
        ifc.rsp_ready = 2'b11;
        #1; chk("t2_g0", ifc.req_ready, 2'b01); tick();
        #1; chk("t2_g1", ifc.req_ready, 2'b10); tick();
        #1; chk("t2_g2", ifc.req_ready, 2'b01); tick();
        #1; chk("t2_g3", ifc.req_ready, 2'b10); tick();
        ifc.req_valid = 2'b00;
        chk("t2_cnt0",      grant_cnt0,    4'd2);
        chk("t2_cnt1",      grant_cnt1,    4'd2);
        chk("t2_rsp_valid", ifc.rsp_valid, 2'b10);
        tick();
        chk("t2_drained", ifc.rsp_valid, 2'b00);

        // 3: port 0 response held off, port 1 waits, then swap in one cycle
        ifc.req0_a = 32'd3; ifc.req0_b = 32'd4; ifc.req0_op = 3'b000;
        ifc.req_valid = 2'b01;
        ifc.rsp_ready = 2'b00;
        #1;
        chk("t3_req_ready", ifc.req_ready, 2'b01);
        tick();
        ifc.req1_a = 32'd7; ifc.req1_b = 32'd7; ifc.req1_op = 3'b000;
        ifc.req_valid = 2'b10;
        #1; chk("t3_stall0_ready", ifc.req_ready, 2'b00);
        chk("t3_stall0_out", ifc.rsp_out, 1'b0); chk("t3_stall0_valid", ifc.rsp_valid, 2'b01); tick();
        #1; chk("t3_stall1_ready", ifc.req_ready, 2'b00);
        chk("t3_stall1_out", ifc.rsp_out, 1'b0); chk("t3_stall1_valid", ifc.rsp_valid, 2'b01); tick();
        #1; chk("t3_stall2_ready", ifc.req_ready, 2'b00);
        chk("t3_stall2_out", ifc.rsp_out, 1'b0); chk("t3_stall2_valid", ifc.rsp_valid, 2'b01); tick();
        ifc.rsp_ready = 2'b01;
        #1;
        chk("t3_swap_ready", ifc.req_ready, 2'b10);
        tick();
        chk("t3_swap_valid", ifc.rsp_valid, 2'b10);
        chk("t3_swap_out",   ifc.rsp_out,   1'b1);
        ifc.req_valid = 2'b00;
        ifc.rsp_ready = 2'b11;
        tick();
        chk("t3_cnt0", grant_cnt0, 4'd3);
        chk("t3_cnt1", grant_cnt1, 4'd3);

        // 4: 20 back-to-back grants to port 0 saturate a 4-bit counter
        ifc.req_valid = 2'b01;
        repeat (20) tick();
        chk("t4_sat_cnt0", grant_cnt0, 4'd15);
        chk("t4_sat_cnt1", grant_cnt1, 4'd3);
        clr_cnt = 1'b1;
        #1;
        chk("t4_clr_ready", ifc.req_ready, 2'b01);
        tick();
        clr_cnt = 1'b0;
        chk("t4_clr_cnt0",  grant_cnt0,    4'd0);
        chk("t4_clr_cnt1",  grant_cnt1,    4'd0);
        chk("t4_clr_valid", ifc.rsp_valid, 2'b01);
        // one more port 0 grant, then leave its response pending
        tick();
        ifc.req_valid = 2'b00;
        ifc.rsp_ready = 2'b00;
        chk("t4_cnt0_after", grant_cnt0, 4'd1);

        // 5: asynchronous reset with a pending response
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", ifc.rsp_valid, 2'b00);
        chk("t5_rst_cnt0",  grant_cnt0,    4'd0);
        #1 rst_n = 1'b1;
        ifc.req_valid = 2'b11;
        ifc.rsp_ready = 2'b11;
        #1;
        chk("t5_tie_ready", ifc.req_ready, 2'b01);
        tick();
        chk("t5_tie_valid", ifc.rsp_valid, 2'b01);
        chk("t5_tie_cnt0",  grant_cnt0,    4'd1);
        ifc.req_valid = 2'b00;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
